// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: NREQ per-requester FIFOs feed one registered regfile write port.
// One grant per cycle, no push-to-grant bypass; req_ready drops only when a FIFO holds DEPTH entries.
module rf_wb_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 3,
    parameter  int DEPTH = 2,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [5*NREQ-1:0]       req_rd,
    input  logic [WIDTH*NREQ-1:0]   req_data,
    output logic                    rf_w_en,
    output logic [4:0]              rf_rd_addr,
    output logic [WIDTH-1:0]        rf_w_data,
    output logic [IDW-1:0]          grant_id,
    output logic                    idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       r_mem_rd  [NREQ][DEPTH];
    logic [WIDTH-1:0] r_mem_dat [NREQ][DEPTH];
    logic [PW-1:0]    r_wp      [NREQ];
    logic [PW-1:0]    r_rp      [NREQ];
    logic [CW-1:0]    r_cnt     [NREQ];
    logic [IDW-1:0]   r_rr_ptr;

    logic [NREQ-1:0]  w_push;
    logic [NREQ-1:0]  w_pop;
    logic [NREQ-1:0]  w_nonempty;
    logic             w_gnt;
    logic [IDW-1:0]   w_winner;

    // Pushes to x0 are acknowledged but never stored.
    always_comb begin
        w_nonempty = '0;
        req_ready  = '0;
        w_push     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            req_ready[i]  = (r_cnt[i] != CW'(DEPTH));
            w_push[i]     = req_valid[i] & req_ready[i] & (req_rd[5*i +: 5] != 5'd0);
        end
    end

    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_gnt    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_gnt && w_nonempty[IDW'(v_idx)]) begin
                w_gnt    = 1'b1;
                w_winner = IDW'(v_idx);
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pop[i] = w_gnt && (w_winner == IDW'(i));
        end
    end

    always_comb begin
        idle = (w_nonempty == '0) && !rf_w_en;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_push[i]) begin
                r_mem_rd[i][r_wp[i]]  <= req_rd[5*i +: 5];
                r_mem_dat[i][r_wp[i]] <= req_data[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_rr_ptr   <= '0;
            rf_w_en    <= 1'b0;
            rf_rd_addr <= '0;
            rf_w_data  <= '0;
            grant_id   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
                if (w_pop[i])  r_rp[i] <= r_rp[i] + 1'b1;
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            // Address, data and grant_id keep their last value when nothing is granted.
            rf_w_en <= w_gnt;
            if (w_gnt) begin
                rf_rd_addr <= r_mem_rd[w_winner][r_rp[w_winner]];
                rf_w_data  <= r_mem_dat[w_winner][r_rp[w_winner]];
                grant_id   <= w_winner;
                r_rr_ptr   <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and random stimulus against a queue-based reference of the write-back arbiter.
module tb_rf_wb_arbiter;
    localparam int W = 32;
    localparam int N = 3;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [5*N-1:0] req_rd;
    logic [W*N-1:0] req_data;
    logic           rf_w_en;
    logic [4:0]     rf_rd_addr;
    logic [W-1:0]   rf_w_data;
    logic [1:0]     grant_id;
    logic           idle;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.WIDTH(W), .NREQ(N), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .rf_w_en    (rf_w_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_w_data  (rf_w_data),
        .grant_id   (grant_id),
        .idle       (idle)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_disc = 0;
    int n_wr   = 0;

    // Reference: one queue of {rd,data} per requester plus the expected write-port contents.
    logic [36:0] mq [N][$];
    int          m_rr;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_dat;
    int          m_gid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr   = 0;
        m_en   = 1'b0;
        m_addr = '0;
        m_dat  = '0;
        m_gid  = 0;
    endtask

    task automatic step(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input bit do_rst = 1'b0);
        logic [2:0]  exp_rdy;
        logic [4:0]  rds [N];
        logic [31:0] dds [N];
        bit          all_empty;
        int          win;
        rds[0] = r0; rds[1] = r1; rds[2] = r2;
        dds[0] = d0; dds[1] = d1; dds[2] = d2;
        rst       = do_rst;
        req_valid = v;
        req_rd    = {r2, r1, r0};
        req_data  = {d2, d1, d0};
        #1;
        all_empty = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = (mq[i].size() != D);
            if (mq[i].size() != 0) all_empty = 1'b0;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("idle", 64'(idle), 64'(all_empty && !m_en));
        @(posedge clk);
        if (do_rst) begin
            for (int i = 0; i < N; i++) n_disc += mq[i].size();
            model_reset();
        end else begin
            win = -1;
            for (int k = 0; k < N; k++)
                if (win < 0 && mq[(m_rr + k) % N].size() > 0) win = (m_rr + k) % N;
            if (win >= 0) begin
                {m_addr, m_dat} = mq[win].pop_front();
                m_en  = 1'b1;
                m_gid = win;
                m_rr  = (win + 1) % N;
            end else begin
                m_en = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i] && rds[i] != 5'd0) begin
                    mq[i].push_back({rds[i], dds[i]});
                    n_acc++;
                end
            end
        end
        #1;
        if (rf_w_en === 1'b1) n_wr++;
        chk("rf_w_en", 64'(rf_w_en), 64'(m_en));
        chk("rf_rd_addr", 64'(rf_rd_addr), 64'(m_addr));
        chk("rf_w_data", 64'(rf_w_data), 64'(m_dat));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
    endtask

    task automatic idle_steps(input int n);
        for (int j = 0; j < n; j++) step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic reset_step();
        step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        int          wr_before;
        bit          saw_bp;
        logic [4:0]  ra, rb, rc;
        rst       = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_w_en", 64'(rf_w_en), 64'd0);
        chk("reset_addr", 64'(rf_rd_addr), 64'd0);
        chk("reset_data", 64'(rf_w_data), 64'd0);
        chk("reset_gid", 64'(grant_id), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'b111);
        chk("reset_idle", 64'(idle), 64'd1);

        // Single push from requester 1
        step(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'd0);
        idle_steps(1);
        chk("t1_en", 64'(rf_w_en), 64'd1);
        chk("t1_addr", 64'(rf_rd_addr), 64'd5);
        chk("t1_data", 64'(rf_w_data), 64'hDEAD_BEEF);
        chk("t1_gid", 64'(grant_id), 64'd1);
        idle_steps(1);
        chk("t1_idle_after", 64'(idle), 64'd1);

        // All three push together from rr_ptr=0
        reset_step();
        step(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB1, 32'hC2);
        for (int i = 0; i < N; i++) begin
            idle_steps(1);
            chk("t2_gid", 64'(grant_id), 64'(i));
            chk("t2_addr", 64'(rf_rd_addr), 64'(i + 1));
        end
        idle_steps(2);

        // Fairness: after granting 1, pointer wraps so 0 goes before 1
        reset_step();
        step(3'b010, 5'd0, 5'd7, 5'd0, 32'd0, 32'h77, 32'd0);
        step(3'b011, 5'd9, 5'd8, 5'd0, 32'h99, 32'h88, 32'd0);
        chk("t3_first_gid", 64'(grant_id), 64'd1);
        idle_steps(1);
        chk("t3_wrap_gid", 64'(grant_id), 64'd0);
        chk("t3_wrap_addr", 64'(rf_rd_addr), 64'd9);
        idle_steps(1);
        chk("t3_next_gid", 64'(grant_id), 64'd1);
        chk("t3_next_addr", 64'(rf_rd_addr), 64'd8);
        idle_steps(2);

        // Saturation: all requesters valid every cycle
        reset_step();
        saw_bp = 1'b0;
        for (int j = 0; j < 30; j++) begin
            ra = 5'($urandom_range(1, 31));
            rb = 5'($urandom_range(1, 31));
            rc = 5'($urandom_range(1, 31));
            step(3'b111, ra, rb, rc, $urandom, $urandom, $urandom);
            if (req_ready[0] === 1'b0) saw_bp = 1'b1;
        end
        chk("t4_backpressure_seen", 64'(saw_bp), 64'd1);
        idle_steps(8);

        // x0 writes are swallowed
        reset_step();
        wr_before = n_wr;
        step(3'b001, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        idle_steps(3);
        chk("t5_idle", 64'(idle), 64'd1);
        chk("t5_no_write", 64'(n_wr), 64'(wr_before));

        // Reset with entries queued
        reset_step();
        step(3'b111, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'h3);
        step(3'b111, 5'd7, 5'd8, 5'd9, 32'h4, 32'h5, 32'h6);
        reset_step();
        chk("t6_en", 64'(rf_w_en), 64'd0);
        chk("t6_idle", 64'(idle), 64'd1);
        chk("t6_ready", 64'(req_ready), 64'b111);
        idle_steps(4);

        // Random traffic, including rd=0 pushes
        for (int j = 0; j < 300; j++) begin
            ra = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rc = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step(3'($urandom), ra, rb, rc, $urandom, $urandom, $urandom);
        end
        idle_steps(10);
        chk("total_writes", 64'(n_wr), 64'(n_acc - n_disc));
        chk("final_idle", 64'(idle), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
